// File: rtl/mux4_rr_arbiter_if.sv
// Shared 1-bit channel bundle between four requesters, the arbiter and the consumer.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out;
  logic       out_valid;
  logic       busy;

  modport master (
    output req, din,
    input  grant, sel, out, out_valid, busy
  );

  modport slave (
    input  req, din,
    output grant, sel, out, out_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a 4:1 one-bit mux: bounded-burst grants, registered select,
// and a registered copy of the selected data bit with a valid flag.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       grant_q, grant_nxt;
  logic [1:0]       sel_q, sel_nxt;
  logic [1:0]       ptr_q, ptr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             out_q, out_valid_q;

  logic [3:0]       req_cand;
  logic [1:0]       scan_idx;
  logic [1:0]       winner;
  logic             win_any;
  logic             hold_ok;
  logic             busy;
  logic             data_take;

  assign busy = (state == GRANT);

  // grant_q is zero in IDLE, so masking the current grantee is harmless there.
  assign req_cand = bus.req & ~grant_q;

  assign hold_ok   = busy && bus.req[sel_q] && (cnt_q < CNT_W'(MAX_HOLD));
  assign data_take = busy && bus.req[sel_q];

  // Rotating-priority scan starting just after the last winner.
  always_comb begin
    winner   = '0;
    win_any  = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_any && req_cand[scan_idx]) begin
        winner  = scan_idx;
        win_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = win_any ? GRANT : IDLE;
      GRANT:   state_nxt = (hold_ok || win_any) ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = grant_q;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt_q;
    ptr_nxt   = ptr_q;
    case (state)
      IDLE: begin
        if (win_any) begin
          grant_nxt = 4'b0001 << winner;
          sel_nxt   = winner;
          cnt_nxt   = CNT_W'(1);
          ptr_nxt   = winner;
        end
      end
      GRANT: begin
        if (hold_ok) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end else if (win_any) begin
          grant_nxt = 4'b0001 << winner;
          sel_nxt   = winner;
          cnt_nxt   = CNT_W'(1);
          ptr_nxt   = winner;
        end else begin
          grant_nxt = '0;
          sel_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        grant_nxt = '0;
        sel_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= 2'd3;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      grant_q     <= grant_nxt;
      sel_q       <= sel_nxt;
      cnt_q       <= cnt_nxt;
      ptr_q       <= ptr_nxt;
      out_valid_q <= data_take;
      if (data_take) begin
        out_q <= bus.din[sel_q];
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=1) share stimulus and are
// compared every cycle against a per-instance behavioural model.
module tb_mux4_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4_rr_arbiter_if ifa ();
  mux4_rr_arbiter_if ifb ();

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       out;
    logic       ov;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  typedef struct {
    int   g;      // current grantee, -1 when idle
    int   cnt;
    int   ptr;
    logic out;
    logic ov;
  } mstate_t;

  exp_t    exp_q[$];
  mstate_t ma, mb;
  int      n_checks = 0;
  int      n_fail   = 0;

  function automatic mstate_t mreset();
    mstate_t s;
    s.g = -1; s.cnt = 0; s.ptr = 3; s.out = 1'b0; s.ov = 1'b0;
    return s;
  endfunction

  function automatic int pick(logic [3:0] r, int ptr);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (ptr + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic mstate_t step(mstate_t s, logic [3:0] r, logic [3:0] d, int mh);
    mstate_t    n;
    logic [3:0] others;
    n = s;
    n.ov = (s.g >= 0) && r[s.g];
    if (n.ov) n.out = d[s.g];
    if (s.g < 0) begin
      if (r != 4'b0) begin
        n.g = pick(r, s.ptr); n.cnt = 1; n.ptr = n.g;
      end
    end else if (r[s.g] && s.cnt < mh) begin
      n.cnt = s.cnt + 1;
    end else begin
      others = r & ~(4'(1 << s.g));
      if (others != 4'b0) begin
        n.g = pick(others, s.ptr); n.cnt = 1; n.ptr = n.g;
      end else begin
        n.g = -1; n.cnt = 0;
      end
    end
    return n;
  endfunction

  function automatic obs_t obs(mstate_t s);
    obs_t o;
    o.grant = (s.g < 0) ? 4'b0 : 4'(1 << s.g);
    o.sel   = (s.g < 0) ? 2'd0 : 2'(s.g);
    o.busy  = (s.g >= 0);
    o.out   = s.out;
    o.ov    = s.ov;
    return o;
  endfunction

  task automatic check_obs(input obs_t act, input obs_t expv, input string nm);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got grant=%b sel=%0d busy=%b out=%b out_valid=%b, expected grant=%b sel=%0d busy=%b out=%b out_valid=%b",
               nm, $time, act.grant, act.sel, act.busy, act.out, act.ov,
               expv.grant, expv.sel, expv.busy, expv.out, expv.ov);
    end
  endtask

  function automatic obs_t sample_a();
    return {ifa.grant, ifa.sel, ifa.busy, ifa.out, ifa.out_valid};
  endfunction

  function automatic obs_t sample_b();
    return {ifb.grant, ifb.sel, ifb.busy, ifb.out, ifb.out_valid};
  endfunction

  // One stimulus cycle: drive at the falling edge, predict the effect of the next rising edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic rv);
    obs_t zero_a, zero_b;
    logic was_up;
    @(negedge clk);
    was_up = rst_n;
    rst_n = rv;
    ifa.req = r; ifa.din = d;
    ifb.req = r; ifb.din = d;
    if (!rv) begin
      ma = mreset();
      mb = mreset();
      if (was_up) begin
        #1;
        zero_a = sample_a();
        zero_b = sample_b();
        zero_a.out = 1'b0;
        zero_b.out = 1'b0;
        check_obs(zero_a, obs(ma), "async_reset_a");
        check_obs(zero_b, obs(mb), "async_reset_b");
      end
    end else begin
      ma = step(ma, r, d, 4);
      mb = step(mb, r, d, 1);
    end
    exp_q.push_back({obs(ma), obs(mb)});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_obs(sample_a(), e.a, "dut_a");
        check_obs(sample_b(), e.b, "dut_b");
      end
    end
  end

  initial begin : driver
    logic [3:0] r;
    logic [3:0] d;
    logic       rv;
    ma = mreset();
    mb = mreset();
    ifa.req = '0; ifa.din = '0;
    ifb.req = '0; ifb.din = '0;

    repeat (3) cycle(4'b0000, 4'b0000, 1'b0);
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1);

    repeat (12) cycle(4'b0100, 4'b0100, 1'b1);
    repeat (2)  cycle(4'b0000, 4'b0000, 1'b1);

    repeat (20) cycle(4'b1111, 4'b1101, 1'b1);
    repeat (2)  cycle(4'b0000, 4'b1101, 1'b1);

    // Pointer now sits at 3, so requester 0 wins first; drop req[0] on its second hold cycle.
    repeat (2) cycle(4'b0011, 4'b0001, 1'b1);
    repeat (4) cycle(4'b0010, 4'b0010, 1'b1);
    repeat (2) cycle(4'b0000, 4'b0000, 1'b1);

    repeat (2) cycle(4'b0010, 4'b0010, 1'b1);
    repeat (2) cycle(4'b1111, 4'b1111, 1'b0);
    repeat (6) cycle(4'b1111, 4'b0110, 1'b1);

    repeat (8) cycle(4'b1010, 4'b1010, 1'b1);

    r = 4'b0;
    for (int unsigned n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d  = 4'($urandom);
      rv = ($urandom_range(0, 199) != 0);
      cycle(r, d, rv);
    end

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 one-bit mux datapath among four requesters. It generates the 2-bit mux select and a one-hot grant, and holds each grant for a bounded burst. It also registers the selected data bit with a valid flag. It sits between four requesting agents and the downstream consumer of the shared 1-bit channel.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one requester may keep the grant (legal 1..15)
CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i
din  input  4  data bit per requester; din[i] is mux input i
grant  output  4  registered one-hot grant; all-zero when idle
sel  output  2  registered mux select = index of granted requester; 2'b00 when idle
out  output  1  registered mux output = din[sel] sampled while granted
out_valid  output  1  high for exactly the cycles in which out carries granted data
busy  output  1  high while in GRANT state

Behaviour:
- Reset: while rst_n=0, asynchronously force grant=0, sel=0, out=0, out_valid=0, busy=0, hold counter=0, state=IDLE, priority pointer ptr=3, so requester 0 has top priority first. Deassertion takes effect at the next clk edge. Reset asserted mid-burst aborts the burst immediately; no partial output is retained.
- Two states: IDLE, GRANT.
- Winner selection is combinational. Scan indices ptr+1, ptr+2, ptr+3, ptr+4, all mod 4. The first index with req set wins.
- IDLE -> GRANT: at a clk edge where req!=0. Load grant=onehot(winner), sel=winner, cnt=1, ptr=winner, busy=1. With no req, remain IDLE and keep outputs at reset values (out holds its last value, out_valid=0).
- GRANT hold: at each edge, the burst continues if req[sel]=1 and cnt<MAX_HOLD. On continue, cnt increments and grant/sel are unchanged.
- GRANT release: at an edge where req[sel]=0 or cnt==MAX_HOLD, release the grant. The winner is computed with the current grantee's request masked off.
  - If any other request remains, hand off directly in the same edge: grant/sel = new winner, cnt=1, ptr=new winner. No idle bubble.
  - If no other request remains, go to IDLE with grant=0, busy=0.
  - If the only remaining request is the current grantee at cnt==MAX_HOLD, it must still release. Enter IDLE for exactly one cycle, then regrant.
- Data path: at each edge, out_valid <= busy && req[sel]. When that is true, out <= din[sel]; otherwise out holds its value. Latency is one cycle from grant to out/out_valid.
- A requester dropping req while granted produces no out_valid for that cycle. Release follows at the same edge.
- Simultaneous requests: exactly one grant is ever set; grant is never multi-hot.
- Fairness: with all four req high continuously, grant order is 0,1,2,3,0,... with MAX_HOLD cycles each.
- X on req or din is not sanitized. Behaviour with X input is undefined, but grant must remain one-hot or zero in simulation with known inputs.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, req=0, then release -> grant=0000, sel=00, busy=0, out_valid=0 throughout.
- Single requester burst: req=0100 held, din=0100 -> one edge later grant=0100, sel=10. out=1 with out_valid=1 for 4 cycles. One IDLE cycle (grant=0000), then regrant of 0100.
- Full contention: req=1111 held for 20 cycles, din=1101 -> grant sequence 0001,0010,0100,1000, each 4 cycles with no gaps. out follows din[sel]: 1,0,1,1 per burst.
- Early release/handoff: grant on 0001 with req=0011; drop req[0] at hold cycle 2 -> next edge grant=0010, cnt=1, no idle cycle. out_valid=0 for the dropped cycle.
- Reset mid-burst: grant=0010, cnt=2, assert rst_n=0 between edges -> grant=0000, sel=00, out_valid=0 immediately (asynchronously). After release with req=1111 -> first grant=0001.
- MAX_HOLD=1 override: req=1010 held -> grant alternates 0010,1000 every cycle. out_valid stays 1 continuously.
